rs: RTL and testbench

//  Tomasulo-style issue/execute back end. Accepts one decoded instruction per cycle from the fetch stage.

---
 rtl/rs_pkg.sv | 37 +++
 rtl/rs_station.sv | 151 +++++++++++++++
 rtl/rs.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_rs.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared opcodes, tag encoding and queue-entry layouts for the rs back end.
package rs_pkg;
  localparam int WORD_W = 32;
  localparam int TAG_W  = 8;

  localparam logic [TAG_W-1:0] TAG_READY = 8'h7F;

  localparam logic [2:0] UNIT_LW   = 3'b000;
  localparam logic [2:0] UNIT_SW   = 3'b001;
  localparam logic [2:0] UNIT_ADD  = 3'b010;
  localparam logic [2:0] UNIT_MUL  = 3'b011;
  localparam logic [2:0] UNIT_MV   = 3'b100;
  localparam logic [2:0] UNIT_HALT = 3'b101;

  typedef struct packed {
    logic              valid;
    logic              issued;
    logic [TAG_W-1:0]  qa;
    logic [WORD_W-1:0] va;
    logic [TAG_W-1:0]  qb;
    logic [WORD_W-1:0] vb;
  } entry_t;

  typedef struct packed {
    logic              store;
    logic [TAG_W-1:0]  qa;
    logic [WORD_W-1:0] va;
    logic [TAG_W-1:0]  qb;
    logic [WORD_W-1:0] vb;
    logic [TAG_W-1:0]  qd;
    logic [WORD_W-1:0] vd;
  } lsq_t;

  function automatic logic [TAG_W-1:0] make_tag(input logic [2:0] u, input logic [3:0] slot);
    return {1'b0, u, slot};
  endfunction
endpackage

// File: rtl/rs_station.sv
// Generic ALU reservation station: RS_DEPTH slots, oldest-ready issue, LAT-stage
// result pipeline whose last stage holds the result until the CDB grants it.
module rs_station
  import rs_pkg::*;
#(
  parameter int         RS_DEPTH = 2,
  parameter int         LAT      = 1,
  parameter logic [2:0] OP       = UNIT_ADD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_en,
  input  logic [TAG_W-1:0]  disp_qa,
  input  logic [WORD_W-1:0] disp_va,
  input  logic [TAG_W-1:0]  disp_qb,
  input  logic [WORD_W-1:0] disp_vb,
  input  logic              cdb_vld,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [WORD_W-1:0] cdb_val,
  input  logic              grant,
  output logic              full,
  output logic [3:0]        free_slot,
  output logic              req,
  output logic [TAG_W-1:0]  req_tag,
  output logic [WORD_W-1:0] req_val
);
  entry_t            ent_q [RS_DEPTH];
  entry_t            ent_d [RS_DEPTH];
  logic [7:0]        age_q [RS_DEPTH];
  logic [7:0]        age_d [RS_DEPTH];
  logic [LAT-1:0]    pv_q, pv_d;
  logic [LAT:0]      adv;
  logic [TAG_W-1:0]  pt_q [LAT];
  logic [TAG_W-1:0]  pt_d [LAT];
  logic [WORD_W-1:0] pd_q [LAT];
  logic [WORD_W-1:0] pd_d [LAT];
  logic              iss_ok, iss_go, has_free;
  int                iss_idx, free_idx;
  logic [7:0]        best_age;
  entry_t            ne;

  function automatic logic [WORD_W-1:0] exec_op(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
    logic signed [WORD_W-1:0] sa, sb, prod;
    sa = a;
    sb = b;
    prod = sa * sb;
    case (OP)
      UNIT_MUL: exec_op = prod;
      UNIT_MV:  exec_op = b;
      default:  exec_op = a + b;
    endcase
  endfunction

  assign req     = pv_q[LAT-1];
  assign req_tag = pt_q[LAT-1];
  assign req_val = pd_q[LAT-1];

  // A stage may accept new data when empty or when everything ahead of it moves.
  always_comb begin
    adv[LAT] = grant;
    for (int k = LAT-1; k >= 0; k--) adv[k] = !pv_q[k] || adv[k+1];
  end

  always_comb begin
    ent_d = ent_q;
    age_d = age_q;
    pv_d  = pv_q;
    pt_d  = pt_q;
    pd_d  = pd_q;
    has_free = 1'b0;
    free_idx = 0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        has_free = 1'b1;
        free_idx = i;
      end
    end
    iss_ok   = 1'b0;
    iss_idx  = 0;
    best_age = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ent_q[i].valid && !ent_q[i].issued && ent_q[i].qa == TAG_READY &&
          ent_q[i].qb == TAG_READY && (!iss_ok || age_q[i] > best_age)) begin
        iss_ok   = 1'b1;
        iss_idx  = i;
        best_age = age_q[i];
      end
    end
    iss_go = iss_ok && adv[0];
    for (int k = 1; k < LAT; k++) begin
      if (adv[k]) begin
        pv_d[k] = pv_q[k-1];
        pt_d[k] = pt_q[k-1];
        pd_d[k] = pd_q[k-1];
      end
    end
    if (adv[0]) begin
      pv_d[0] = iss_go;
      pt_d[0] = make_tag(OP, 4'(iss_idx));
      pd_d[0] = exec_op(ent_q[iss_idx].va, ent_q[iss_idx].vb);
    end
    if (iss_go) ent_d[iss_idx].issued = 1'b1;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant && pt_q[LAT-1] == make_tag(OP, 4'(i))) ent_d[i].valid = 1'b0;
      if (cdb_vld && ent_q[i].qa == cdb_tag) begin
        ent_d[i].qa = TAG_READY;
        ent_d[i].va = cdb_val;
      end
      if (cdb_vld && ent_q[i].qb == cdb_tag) begin
        ent_d[i].qb = TAG_READY;
        ent_d[i].vb = cdb_val;
      end
      if (ent_q[i].valid && age_q[i] != 8'hFF) age_d[i] = age_q[i] + 8'd1;
    end
    // An operand whose producer broadcasts in the dispatch cycle is caught here.
    ne = '{valid: 1'b1, issued: 1'b0, qa: disp_qa, va: disp_va, qb: disp_qb, vb: disp_vb};
    if (cdb_vld && disp_qa == cdb_tag) begin
      ne.qa = TAG_READY;
      ne.va = cdb_val;
    end
    if (cdb_vld && disp_qb == cdb_tag) begin
      ne.qb = TAG_READY;
      ne.vb = cdb_val;
    end
    if (disp_en && has_free) begin
      ent_d[free_idx] = ne;
      age_d[free_idx] = '0;
    end
    full      = !has_free;
    free_slot = 4'(free_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= '0;
        age_q[i] <= '0;
      end
      pv_q <= '0;
    end else begin
      ent_q <= ent_d;
      age_q <= age_d;
      pv_q  <= pv_d;
    end
  end

  always_ff @(posedge clk) begin
    pt_q <= pt_d;
    pd_q <= pd_d;
  end
endmodule

// File: rtl/rs.sv
// Tomasulo issue/execute back end: tag table, register file, in-order LSQ, CDB arbiter.
// Define RS_BYPASS_EN to forward the tag broadcast this cycle to dispatch and the read port.
module rs
  import rs_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int REG_SIZE   = 6,
  parameter int UNIT_SIZE  = 8,
  parameter int RS_DEPTH   = 2,
  parameter int LSQ_DEPTH  = 4,
  parameter int DMEM_WORDS = 256,
  parameter int MUL_LAT    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           unit,
  input  logic [REG_SIZE-1:0]  reg1,
  input  logic [REG_SIZE-1:0]  reg2,
  input  logic [REG_SIZE-1:0]  reg3,
  input  logic                 hasimm,
  input  logic [WORD_SIZE-1:0] imm,
  input  logic                 enable,
  output logic                 out,
  input  logic                 regread,
  input  logic [REG_SIZE-1:0]  regin,
  output logic [UNIT_SIZE-1:0] regout,
  output logic [WORD_SIZE-1:0] regoutrf
);
  localparam int NREG = 1 << REG_SIZE;
  localparam int AW   = $clog2(DMEM_WORDS);
  localparam int QW   = $clog2(LSQ_DEPTH);

  logic [WORD_SIZE-1:0] rf_q   [NREG];
  logic [WORD_SIZE-1:0] rf_d   [NREG];
  logic [UNIT_SIZE-1:0] tag_q  [NREG];
  logic [UNIT_SIZE-1:0] tag_d  [NREG];
  logic [WORD_SIZE-1:0] dmem_q [DMEM_WORDS];
  logic [WORD_SIZE-1:0] dmem_d [DMEM_WORDS];
  lsq_t                 lsq_q  [LSQ_DEPTH];
  lsq_t                 lsq_d  [LSQ_DEPTH];
  logic                 halted_q, halted_d;
  logic [QW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [QW:0]          cnt_q, cnt_d;
  logic                 lw_iss_q, lw_iss_d, lwa_vld_q, lwa_vld_d, lwd_vld_q, lwd_vld_d;
  logic [AW-1:0]        lwa_addr_q, lwa_addr_d;
  logic [WORD_SIZE-1:0] lwd_val_q, lwd_val_d;
  logic [UNIT_SIZE-1:0] lwd_tag_q, lwd_tag_d;

  logic                 cdb_vld, lw_gnt, mul_gnt, add_gnt, mv_gnt;
  logic [UNIT_SIZE-1:0] cdb_tag;
  logic [WORD_SIZE-1:0] cdb_val;
  logic                 add_full, mul_full, mv_full, add_req, mul_req, mv_req;
  logic [3:0]           add_slot, mul_slot, mv_slot;
  logic [UNIT_SIZE-1:0] add_tag, mul_tag, mv_tag;
  logic [WORD_SIZE-1:0] add_val, mul_val, mv_val;

  logic [REG_SIZE-1:0]  rd_idx [4];
  logic [UNIT_SIZE-1:0] rd_tag [4];
  logic [WORD_SIZE-1:0] rd_val [4];
  logic [UNIT_SIZE-1:0] op_qa, op_qb;
  logic [WORD_SIZE-1:0] op_va, op_vb;
  logic                 disp, push, pop, h_rdy;
  lsq_t                 hd, ne;
  logic [WORD_SIZE-1:0] h_addr;

  // Read ports: 0 = src A, 1 = src B, 2 = store data, 3 = fetch read port.
  always_comb begin
    rd_idx[0] = reg2;
    rd_idx[1] = reg3;
    rd_idx[2] = reg1;
    rd_idx[3] = regin;
    for (int p = 0; p < 4; p++) begin
      rd_tag[p] = tag_q[rd_idx[p]];
      rd_val[p] = rf_q[rd_idx[p]];
`ifdef RS_BYPASS_EN
      if (cdb_vld && rd_tag[p] == cdb_tag) begin
        rd_tag[p] = TAG_READY;
        rd_val[p] = cdb_val;
      end
`endif
    end
  end

  assign regout   = regread ? rd_tag[3] : TAG_READY;
  assign regoutrf = rd_val[3];

  always_comb begin
    out = 1'b0;
    if (!halted_q) begin
      case (unit)
        UNIT_LW, UNIT_SW: out = (cnt_q != (QW+1)'(LSQ_DEPTH));
        UNIT_ADD:         out = !add_full;
        UNIT_MUL:         out = !mul_full;
        UNIT_MV:          out = !mv_full;
        UNIT_HALT:        out = 1'b1;
        default:          out = 1'b0;
      endcase
    end
  end

  assign disp = enable && out;

  always_comb begin
    op_qa = rd_tag[0];
    op_va = rd_val[0];
    op_qb = hasimm ? TAG_READY : rd_tag[1];
    op_vb = hasimm ? imm : rd_val[1];
    if (unit == UNIT_MV) begin
      op_qa = TAG_READY;
      op_va = '0;
      op_qb = hasimm ? TAG_READY : rd_tag[0];
      op_vb = hasimm ? imm : rd_val[0];
    end
  end

  rs_station #(.RS_DEPTH(RS_DEPTH), .LAT(1), .OP(UNIT_ADD)) u_add (
    .clk(clk), .rst_n(rst_n), .disp_en(disp && unit == UNIT_ADD),
    .disp_qa(op_qa), .disp_va(op_va), .disp_qb(op_qb), .disp_vb(op_vb),
    .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .grant(add_gnt),
    .full(add_full), .free_slot(add_slot), .req(add_req), .req_tag(add_tag), .req_val(add_val));

  rs_station #(.RS_DEPTH(RS_DEPTH), .LAT(MUL_LAT), .OP(UNIT_MUL)) u_mul (
    .clk(clk), .rst_n(rst_n), .disp_en(disp && unit == UNIT_MUL),
    .disp_qa(op_qa), .disp_va(op_va), .disp_qb(op_qb), .disp_vb(op_vb),
    .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .grant(mul_gnt),
    .full(mul_full), .free_slot(mul_slot), .req(mul_req), .req_tag(mul_tag), .req_val(mul_val));

  rs_station #(.RS_DEPTH(RS_DEPTH), .LAT(1), .OP(UNIT_MV)) u_mv (
    .clk(clk), .rst_n(rst_n), .disp_en(disp && unit == UNIT_MV),
    .disp_qa(op_qa), .disp_va(op_va), .disp_qb(op_qb), .disp_vb(op_vb),
    .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .grant(mv_gnt),
    .full(mv_full), .free_slot(mv_slot), .req(mv_req), .req_tag(mv_tag), .req_val(mv_val));

  // Fixed-priority CDB: lw > mul > add > mv.
  always_comb begin
    cdb_vld = 1'b1;
    cdb_tag = lwd_tag_q;
    cdb_val = lwd_val_q;
    lw_gnt  = 1'b0;
    mul_gnt = 1'b0;
    add_gnt = 1'b0;
    mv_gnt  = 1'b0;
    if (lwd_vld_q) begin
      lw_gnt = 1'b1;
    end else if (mul_req) begin
      mul_gnt = 1'b1;
      cdb_tag = mul_tag;
      cdb_val = mul_val;
    end else if (add_req) begin
      add_gnt = 1'b1;
      cdb_tag = add_tag;
      cdb_val = add_val;
    end else if (mv_req) begin
      mv_gnt  = 1'b1;
      cdb_tag = mv_tag;
      cdb_val = mv_val;
    end else begin
      cdb_vld = 1'b0;
    end
  end

  // Writeback precedes rename so a same-cycle dispatch to the same dest keeps its new tag.
  always_comb begin
    rf_d     = rf_q;
    tag_d    = tag_q;
    halted_d = halted_q;
    for (int r = 0; r < NREG; r++) begin
      if (cdb_vld && tag_q[r] == cdb_tag) begin
        rf_d[r]  = cdb_val;
        tag_d[r] = TAG_READY;
      end
    end
    if (disp) begin
      case (unit)
        UNIT_LW:   tag_d[reg1] = make_tag(UNIT_LW, 4'(tail_q));
        UNIT_ADD:  tag_d[reg1] = make_tag(UNIT_ADD, add_slot);
        UNIT_MUL:  tag_d[reg1] = make_tag(UNIT_MUL, mul_slot);
        UNIT_MV:   tag_d[reg1] = make_tag(UNIT_MV, mv_slot);
        UNIT_HALT: halted_d = 1'b1;
        default:   halted_d = halted_q;
      endcase
    end
  end

  always_comb begin
    lsq_d      = lsq_q;
    head_d     = head_q;
    tail_d     = tail_q;
    dmem_d     = dmem_q;
    lw_iss_d   = lw_iss_q;
    lwa_vld_d  = 1'b0;
    lwa_addr_d = lwa_addr_q;
    lwd_vld_d  = lwd_vld_q;
    lwd_val_d  = lwd_val_q;
    lwd_tag_d  = lwd_tag_q;
    push       = 1'b0;
    pop        = 1'b0;
    hd         = lsq_q[head_q];
    h_addr     = hd.va + hd.vb;
    h_rdy      = (cnt_q != '0) && hd.qa == TAG_READY && hd.qb == TAG_READY &&
                 (!hd.store || hd.qd == TAG_READY);
    if (h_rdy && hd.store) begin
      dmem_d[AW'(h_addr)] = hd.vd;
      pop = 1'b1;
    end
    if (h_rdy && !hd.store && !lw_iss_q) begin
      lwa_vld_d  = 1'b1;
      lwa_addr_d = AW'(h_addr);
      lw_iss_d   = 1'b1;
    end
    // At most one load is in flight; it leaves the queue when it wins the CDB.
    if (lw_gnt) begin
      lwd_vld_d = 1'b0;
      lw_iss_d  = 1'b0;
      pop       = 1'b1;
    end
    if (lwa_vld_q) begin
      lwd_vld_d = 1'b1;
      lwd_val_d = dmem_q[lwa_addr_q];
      lwd_tag_d = make_tag(UNIT_LW, 4'(head_q));
    end
    for (int i = 0; i < LSQ_DEPTH; i++) begin
      if (cdb_vld && lsq_q[i].qa == cdb_tag) begin
        lsq_d[i].qa = TAG_READY;
        lsq_d[i].va = cdb_val;
      end
      if (cdb_vld && lsq_q[i].qb == cdb_tag) begin
        lsq_d[i].qb = TAG_READY;
        lsq_d[i].vb = cdb_val;
      end
      if (cdb_vld && lsq_q[i].qd == cdb_tag) begin
        lsq_d[i].qd = TAG_READY;
        lsq_d[i].vd = cdb_val;
      end
    end
    ne = '{store: (unit == UNIT_SW), qa: op_qa, va: op_va, qb: op_qb, vb: op_vb,
           qd: (unit == UNIT_SW) ? rd_tag[2] : TAG_READY, vd: rd_val[2]};
    if (cdb_vld && ne.qa == cdb_tag) begin
      ne.qa = TAG_READY;
      ne.va = cdb_val;
    end
    if (cdb_vld && ne.qb == cdb_tag) begin
      ne.qb = TAG_READY;
      ne.vb = cdb_val;
    end
    if (cdb_vld && ne.qd == cdb_tag) begin
      ne.qd = TAG_READY;
      ne.vd = cdb_val;
    end
    if (disp && (unit == UNIT_LW || unit == UNIT_SW)) begin
      lsq_d[tail_q] = ne;
      push = 1'b1;
    end
    tail_d = tail_q + QW'(push);
    head_d = head_q + QW'(pop);
    cnt_d  = cnt_q + (QW+1)'(push) - (QW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r]  <= '0;
        tag_q[r] <= TAG_READY;
      end
      for (int a = 0; a < DMEM_WORDS; a++) dmem_q[a] <= '0;
      halted_q  <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      lw_iss_q  <= 1'b0;
      lwa_vld_q <= 1'b0;
      lwd_vld_q <= 1'b0;
    end else begin
      rf_q      <= rf_d;
      tag_q     <= tag_d;
      dmem_q    <= dmem_d;
      halted_q  <= halted_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      lw_iss_q  <= lw_iss_d;
      lwa_vld_q <= lwa_vld_d;
      lwd_vld_q <= lwd_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    lsq_q      <= lsq_d;
    lwa_addr_q <= lwa_addr_d;
    lwd_val_q  <= lwd_val_d;
    lwd_tag_q  <= lwd_tag_d;
  end
endmodule

// File: tb/tb_rs.sv
// Scenario bench for rs: register-value expectations queued at dispatch, checked on writeback.
module tb_rs;
  localparam logic [2:0] U_LW = 3'b000, U_SW = 3'b001, U_ADD = 3'b010;
  localparam logic [2:0] U_MUL = 3'b011, U_MV = 3'b100, U_HALT = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  unit = '0;
  logic [5:0]  reg1 = '0, reg2 = '0, reg3 = '0, regin = '0;
  logic        hasimm = 1'b0, enable = 1'b0, regread = 1'b0;
  logic [31:0] imm = '0;
  logic        out;
  logic [7:0]  regout;
  logic [31:0] regoutrf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [5:0]  r;
    logic [31:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  rs dut (
    .clk(clk), .rst_n(rst_n), .unit(unit), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .hasimm(hasimm), .imm(imm), .enable(enable), .out(out), .regread(regread),
    .regin(regin), .regout(regout), .regoutrf(regoutrf)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [2:0] u, input logic [5:0] d, input logic [5:0] a,
                       input logic [5:0] b, input logic hi, input logic [31:0] im);
    int n;
    n = 0;
    @(negedge clk);
    unit = u; reg1 = d; reg2 = a; reg3 = b; hasimm = hi; imm = im; enable = 1'b1;
    #1;
    while (out !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL dispatch unit=%0d r%0d: out=%b, required 1 within 50 cycles", u, d, out);
      enable = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      enable = 1'b0;
    end
  endtask

  task automatic read_reg(input logic [5:0] r, output logic [7:0] t, output logic [31:0] v);
    @(negedge clk);
    regread = 1'b1;
    regin = r;
    #1;
    t = regout;
    v = regoutrf;
  endtask

  task automatic expect_reg(input logic [5:0] r, input logic [31:0] v);
    exp_t e;
    e.r = r;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    exp_t e;
    logic [7:0] t;
    logic [31:0] v;
    int n;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n = 0;
      read_reg(e.r, t, v);
      while (t !== 8'h7F && n < 64) begin
        read_reg(e.r, t, v);
        n++;
      end
      tests++;
      if (t !== 8'h7F) begin
        fails++;
        $display("FAIL %s r%0d: tag=%h, required 7f within 64 cycles", name, e.r, t);
      end else if (v !== e.v) begin
        fails++;
        $display("FAIL %s r%0d: value=%0d, required %0d", name, e.r, $signed(v), $signed(e.v));
      end
    end
  endtask

  task automatic check_out(input logic [2:0] u, input logic req, input string name);
    @(negedge clk);
    unit = u;
    enable = 1'b0;
    #1;
    tests++;
    if (out !== req) begin
      fails++;
      $display("FAIL %s unit=%0d: out=%b, required %b", name, u, out, req);
    end
  endtask

  task automatic test_reset();
    logic [7:0] t;
    logic [31:0] v;
    do_reset();
    read_reg(6'd5, t, v);
    tests++;
    if (t !== 8'h7F) begin fails++; $display("FAIL reset_tag r5: tag=%h, required 7f", t); end
    tests++;
    if (v !== 32'd0) begin fails++; $display("FAIL reset_val r5: value=%0d, required 0", v); end
    for (int u = 0; u < 6; u++) check_out(3'(u), 1'b1, "reset_out");
  endtask

  task automatic test_raw_chain();
    logic [7:0] t;
    logic [31:0] v;
    issue(U_MV, 6'd1, 6'd0, 6'd0, 1'b1, 32'd7);
    expect_reg(6'd1, 32'd7);
    issue(U_ADD, 6'd2, 6'd1, 6'd0, 1'b1, 32'd3);
    expect_reg(6'd2, 32'd10);
    read_reg(6'd2, t, v);
    tests++;
    if (t === 8'h7F) begin fails++; $display("FAIL raw_pending r2: tag=%h, required a pending tag", t); end
    @(negedge clk);
    regread = 1'b0;
    regin = 6'd2;
    #1;
    tests++;
    if (regout !== 8'h7F) begin fails++; $display("FAIL regread_off: regout=%h, required 7f", regout); end
    drain("raw_chain");
  endtask

  task automatic test_station_full();
    issue(U_MUL, 6'd9, 6'd0, 6'd0, 1'b1, 32'd1);
    expect_reg(6'd9, 32'd0);
    issue(U_ADD, 6'd10, 6'd9, 6'd0, 1'b1, 32'd1);
    expect_reg(6'd10, 32'd1);
    issue(U_ADD, 6'd11, 6'd9, 6'd0, 1'b1, 32'd2);
    expect_reg(6'd11, 32'd2);
    check_out(U_ADD, 1'b0, "add_full");
    check_out(U_MUL, 1'b1, "mul_free");
    drain("station_full");
    check_out(U_ADD, 1'b1, "add_reopen");
  endtask

  task automatic test_stale_mul();
    logic [7:0] t;
    logic [31:0] v;
    issue(U_MV, 6'd3, 6'd0, 6'd0, 1'b1, -32'sd4);
    expect_reg(6'd3, -32'sd4);
    issue(U_MUL, 6'd4, 6'd3, 6'd0, 1'b1, 32'd5);
    issue(U_ADD, 6'd4, 6'd3, 6'd0, 1'b1, 32'd1);
    expect_reg(6'd4, -32'sd3);
    drain("stale_mul");
    repeat (12) @(negedge clk);
    read_reg(6'd4, t, v);
    tests++;
    if (t !== 8'h7F || v !== -32'sd3) begin
      fails++;
      $display("FAIL stale_mul_late r4: tag=%h value=%0d, required 7f / -3", t, $signed(v));
    end
  endtask

  task automatic test_lsq();
    issue(U_SW, 6'd1, 6'd0, 6'd0, 1'b1, 32'd8);
    issue(U_LW, 6'd6, 6'd0, 6'd0, 1'b1, 32'd8);
    expect_reg(6'd6, 32'd7);
    issue(U_SW, 6'd2, 6'd0, 6'd0, 1'b1, 32'd264);
    issue(U_LW, 6'd12, 6'd0, 6'd0, 1'b1, 32'd8);
    expect_reg(6'd12, 32'd10);
    issue(U_LW, 6'd13, 6'd2, 6'd0, 1'b1, -32'sd2);
    expect_reg(6'd13, 32'd10);
    issue(U_ADD, 6'd14, 6'd12, 6'd13, 1'b0, 32'd0);
    expect_reg(6'd14, 32'd20);
    drain("lsq");
  endtask

  task automatic test_halt();
    issue(U_MUL, 6'd7, 6'd3, 6'd0, 1'b1, -32'sd6);
    expect_reg(6'd7, 32'd24);
    issue(U_HALT, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0);
    for (int u = 0; u < 6; u++) check_out(3'(u), 1'b0, "halted_out");
    drain("halt_drain");
  endtask

  task automatic test_midreset();
    logic [7:0] t;
    logic [31:0] v;
    do_reset();
    check_out(U_ADD, 1'b1, "unhalt_out");
    issue(U_MV, 6'd8, 6'd0, 6'd0, 1'b1, 32'd5);
    read_reg(6'd8, t, v);
    tests++;
    if (t === 8'h7F) begin fails++; $display("FAIL midreset_pending r8: tag=%h, required a pending tag", t); end
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    read_reg(6'd8, t, v);
    tests++;
    if (t !== 8'h7F || v !== 32'd0) begin
      fails++;
      $display("FAIL midreset r8: tag=%h value=%0d, required 7f / 0", t, v);
    end
  endtask

  initial begin
    test_reset();
    test_raw_chain();
    test_station_full();
    test_stale_mul();
    test_lsq();
    test_halt();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
